// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
//   Owns the register file's single write port and the flag register write.
//   After reset it walks every register address once and writes zero, then
//   shares the port between ALU writeback and load writeback. Returning loads
//   are buffered in a small in-order FIFO. The FIFO also supplies read-after-
//   write hazard detection for decode.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   alu_*_i / _o      ALU writeback request (valid/ready handshake), flags
//   ld_*_i            load return (no backpressure, at most one per cycle)
//   rd_addr_a/b_i     decode read pointers checked against buffered loads
//   rf_wr_*_o         register file write port (combinational, latched by RF)
//   fl_wr_en_o/fl_data_o  flag register write {zero,ngtv,scry}
//   raw_stall_o       a read pointer matches a pending load destination
//   busy_o            clear sequence in progress
//   ld_drop_err_o     sticky: a load arrived while it could not be buffered
// ----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int PW       = 3,
   parameter int DW       = 8,
   parameter int LD_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid_i,
   output logic          alu_ready_o,
   input  logic [PW-1:0] alu_addr_i,
   input  logic [DW-1:0] alu_data_i,
   input  logic          alu_flag_en_i,
   input  logic [2:0]    alu_flags_i,
   input  logic          ld_valid_i,
   input  logic [PW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_data_i,
   input  logic [PW-1:0] rd_addr_a_i,
   input  logic [PW-1:0] rd_addr_b_i,
   output logic          rf_wr_en_o,
   output logic [PW-1:0] rf_wr_addr_o,
   output logic [DW-1:0] rf_wr_data_o,
   output logic          fl_wr_en_o,
   output logic [2:0]    fl_data_o,
   output logic          raw_stall_o,
   output logic          busy_o,
   output logic          ld_drop_err_o
);

   localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LD_DEPTH - 1);
   localparam logic [PW-1:0]    CLR_LAST = {PW{1'b1}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [PW-1:0]        clr_ptr_q, clr_ptr_d;

   // Load FIFO: one valid bit per slot so the hazard check can scan slots directly.
   logic [PW-1:0]        fifo_addr_q [LD_DEPTH];
   logic [DW-1:0]        fifo_data_q [LD_DEPTH];
   logic [LD_DEPTH-1:0]  fifo_vld_q;
   logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
   logic                 ld_drop_err_q;

   logic                 push_s, pop_s, drop_s;
   logic                 fifo_full_s, fifo_empty_s;
   logic                 hit_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = {PTR_W{1'b0}};
      end else begin
         nxt = ptr + 1'b1;
      end
      return nxt;
   endfunction

   assign fifo_full_s   = &fifo_vld_q;
   assign fifo_empty_s  = ~(|fifo_vld_q);
   assign ld_drop_err_o = ld_drop_err_q;

   // FSM state and clear pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= {PW{1'b0}};
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Next state, write-port arbitration and FIFO push/pop decisions.
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      push_s       = 1'b0;
      pop_s        = 1'b0;
      drop_s       = 1'b0;
      alu_ready_o  = 1'b0;
      rf_wr_en_o   = 1'b0;
      rf_wr_addr_o = {PW{1'b0}};
      rf_wr_data_o = {DW{1'b0}};
      fl_wr_en_o   = 1'b0;
      fl_data_o    = 3'b000;
      busy_o       = 1'b1;
      if (reset) begin
         busy_o = 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               rf_wr_en_o   = 1'b1;
               rf_wr_addr_o = clr_ptr_q;
               rf_wr_data_o = {DW{1'b0}};
               // clr_ptr is only zero on the first clear cycle
               fl_wr_en_o   = (clr_ptr_q == {PW{1'b0}});
               fl_data_o    = 3'b000;
               drop_s       = ld_valid_i;
               clr_ptr_d    = clr_ptr_q + 1'b1;
               if (clr_ptr_q == CLR_LAST) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_CLEAR;
               end
            end
            ST_RUN: begin
               busy_o = 1'b0;
               // A full FIFO always pops, so a same-cycle push can never overflow.
               push_s = ld_valid_i;
               if (fifo_full_s) begin
                  pop_s = 1'b1;
               end else if (alu_valid_i) begin
                  alu_ready_o  = 1'b1;
                  rf_wr_en_o   = 1'b1;
                  rf_wr_addr_o = alu_addr_i;
                  rf_wr_data_o = alu_data_i;
                  fl_wr_en_o   = alu_flag_en_i;
                  fl_data_o    = alu_flags_i;
               end else if (!fifo_empty_s) begin
                  pop_s = 1'b1;
               end else begin
                  rf_wr_en_o = 1'b0;
               end
               if (pop_s) begin
                  rf_wr_en_o   = 1'b1;
                  rf_wr_addr_o = fifo_addr_q[rd_ptr_q];
                  rf_wr_data_o = fifo_data_q[rd_ptr_q];
               end else begin
                  rf_wr_en_o   = rf_wr_en_o;
               end
            end
            default: begin
               state_d = ST_CLEAR;
            end
         endcase
      end
   end

   // Load FIFO storage and pointers; on a full push+pop the freed head slot is refilled.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_vld_q <= {LD_DEPTH{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
      end else begin
         if (pop_s) begin
            fifo_vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q             <= next_ptr(rd_ptr_q);
         end
         if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= ld_addr_i;
            fifo_data_q[wr_ptr_q] <= ld_data_i;
            fifo_vld_q[wr_ptr_q]  <= 1'b1;
            wr_ptr_q              <= next_ptr(wr_ptr_q);
         end
      end
   end

   // Sticky drop error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_drop_err_q <= 1'b0;
      end else if (drop_s) begin
         ld_drop_err_q <= 1'b1;
      end else begin
         ld_drop_err_q <= ld_drop_err_q;
      end
   end

   // Hazard scan: pending entries (minus the one leaving now) plus the incoming load.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         hit_s = hit_s | (fifo_vld_q[i]
                          & ~(pop_s & (PTR_W'(i) == rd_ptr_q))
                          & ((fifo_addr_q[i] == rd_addr_a_i) | (fifo_addr_q[i] == rd_addr_b_i)));
      end
      hit_s = hit_s | (push_s & ((ld_addr_i == rd_addr_a_i) | (ld_addr_i == rd_addr_b_i)));
      if (reset) begin
         raw_stall_o = 1'b0;
      end else begin
         raw_stall_o = hit_s;
      end
   end

endmodule
